// File: rtl/spu_fx2_pkg.sv
// Shared types, opcodes and shift/rotate helpers for the even-pipe
// fixed-point shift/rotate unit.
package spu_fx2_pkg;

    localparam int FX2_DATA_W = 128;
    localparam int FX2_ADDR_W = 7;

    // RR opcodes are matched on all 11 bits.
    localparam logic [10:0] OP_SHLH  = 11'b00001011111;
    localparam logic [10:0] OP_SHL   = 11'b00001011011;
    localparam logic [10:0] OP_ROTH  = 11'b00001011100;
    localparam logic [10:0] OP_ROT   = 11'b00001011000;

    // RI7 opcodes are matched on the upper 10 bits only.
    localparam logic [9:0]  OP_SHLHI = 10'b0000111111;
    localparam logic [9:0]  OP_SHLI  = 10'b0000111101;
    localparam logic [9:0]  OP_ROTHI = 10'b0000111110;
    localparam logic [9:0]  OP_ROTI  = 10'b0000111100;

    typedef enum logic [2:0] {
        FMT_RR  = 3'd0,
        FMT_RI7 = 3'd1
    } fmt_e;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_SHLH = 3'd1,
        ALU_SHL  = 3'd2,
        ALU_ROTH = 3'd3,
        ALU_ROT  = 3'd4
    } alu_kind_e;

    // One pipeline slot; an all-zero slot is a bubble.
    typedef struct packed {
        logic [FX2_DATA_W-1:0] data;
        logic [FX2_ADDR_W-1:0] addr;
        logic                  we;
    } stage_t;

    // Halfword shift left; counts 16..31 clear the element.
    function automatic logic [15:0] fx2_shlh(input logic [15:0] v, input logic [4:0] c);
        logic [15:0] r;
        if (c > 5'd15) begin
            r = 16'h0000;
        end else begin
            r = v << c;
        end
        return r;
    endfunction

    // Word shift left; counts 32..63 clear the element.
    function automatic logic [31:0] fx2_shl(input logic [31:0] v, input logic [5:0] c);
        logic [31:0] r;
        if (c > 6'd31) begin
            r = 32'h0000_0000;
        end else begin
            r = v << c;
        end
        return r;
    endfunction

    // Halfword rotate left; a zero count shifts right by 16, which yields 0.
    function automatic logic [15:0] fx2_roth(input logic [15:0] v, input logic [3:0] c);
        return (v << c) | (v >> (5'd16 - {1'b0, c}));
    endfunction

    // Word rotate left.
    function automatic logic [31:0] fx2_rot(input logic [31:0] v, input logic [4:0] c);
        return (v << c) | (v >> (6'd32 - {1'b0, c}));
    endfunction

endpackage

// File: rtl/simple_fixed2_pipe_if.sv
// Issue-side and result-side signal bundle of the shift/rotate pipe.
// Vectors declared [0:N-1] follow the big-endian numbering (bit 0 = MSB).
interface simple_fixed2_pipe_if #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 7
);
    logic [0:10]                 op;
    logic [2:0]                  format;
    logic [ADDR_W-1:0]           rt_addr;
    logic [0:DATA_W-1]           ra;
    logic [0:DATA_W-1]           rb;
    logic [0:17]                 imm;
    logic                        reg_write;
    logic                        stall;
    logic                        flush;
    logic [0:LATENCY*DATA_W-1]   fwd_data;
    logic [0:LATENCY*ADDR_W-1]   fwd_addr;
    logic [0:LATENCY-1]          fwd_we;
    logic [0:DATA_W-1]           rt_wb;
    logic [ADDR_W-1:0]           rt_addr_wb;
    logic                        reg_write_wb;

    modport master (
        output op, format, rt_addr, ra, rb, imm, reg_write, stall, flush,
        input  fwd_data, fwd_addr, fwd_we, rt_wb, rt_addr_wb, reg_write_wb
    );

    modport slave (
        input  op, format, rt_addr, ra, rb, imm, reg_write, stall, flush,
        output fwd_data, fwd_addr, fwd_we, rt_wb, rt_addr_wb, reg_write_wb
    );
endinterface

// File: rtl/fx2_shift_rot_alu.sv
// Combinational halfword/word shift and rotate datapath with opcode decode.
// valid is low for nop, undefined opcodes and unsupported formats.
module fx2_shift_rot_alu
    import spu_fx2_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic [0:10]       op,
    input  logic [2:0]        format,
    input  logic [0:DATA_W-1] ra,
    input  logic [0:DATA_W-1] rb,
    input  logic [0:17]       imm,
    output logic [0:DATA_W-1] result,
    output logic              valid
);

    alu_kind_e   kind_s;
    logic        use_imm_s;
    logic [5:0]  cnt_imm_s;
    logic        unused_s;

    // Every count mask is at most 6 bits wide, so the low bits of the
    // immediate equal the masked sign-extended count.
    assign cnt_imm_s = imm[12:17];
    assign unused_s  = ^{imm[0:11], rb};

    // Decode opcode and format into an operation class and count source
    always_comb begin
        kind_s    = ALU_NONE;
        use_imm_s = 1'b0;
        case (format)
            FMT_RR: begin
                case (op)
                    OP_SHLH: kind_s = ALU_SHLH;
                    OP_SHL:  kind_s = ALU_SHL;
                    OP_ROTH: kind_s = ALU_ROTH;
                    OP_ROT:  kind_s = ALU_ROT;
                    default: kind_s = ALU_NONE;
                endcase
            end
            FMT_RI7: begin
                use_imm_s = 1'b1;
                case (op[0:9])
                    OP_SHLHI: kind_s = ALU_SHLH;
                    OP_SHLI:  kind_s = ALU_SHL;
                    OP_ROTHI: kind_s = ALU_ROTH;
                    OP_ROTI:  kind_s = ALU_ROT;
                    default:  kind_s = ALU_NONE;
                endcase
            end
            default: begin
                kind_s    = ALU_NONE;
                use_imm_s = 1'b0;
            end
        endcase
    end

    assign valid = (kind_s != ALU_NONE);

    // Apply the selected operation to every element; each count comes from the matching rb element
    always_comb begin
        result = '0;
        case (kind_s)
            ALU_SHLH: begin
                for (int h = 0; h < DATA_W / 16; h++) begin
                    result[h*16 +: 16] = fx2_shlh(ra[h*16 +: 16],
                        use_imm_s ? cnt_imm_s[4:0] : rb[h*16+11 +: 5]);
                end
            end
            ALU_ROTH: begin
                for (int h = 0; h < DATA_W / 16; h++) begin
                    result[h*16 +: 16] = fx2_roth(ra[h*16 +: 16],
                        use_imm_s ? cnt_imm_s[3:0] : rb[h*16+12 +: 4]);
                end
            end
            ALU_SHL: begin
                for (int w = 0; w < DATA_W / 32; w++) begin
                    result[w*32 +: 32] = fx2_shl(ra[w*32 +: 32],
                        use_imm_s ? cnt_imm_s : rb[w*32+26 +: 6]);
                end
            end
            ALU_ROT: begin
                for (int w = 0; w < DATA_W / 32; w++) begin
                    result[w*32 +: 32] = fx2_rot(ra[w*32 +: 32],
                        use_imm_s ? cnt_imm_s[4:0] : rb[w*32+27 +: 5]);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/simple_fixed2_pipe.sv
// Even-pipe fixed-point shift/rotate unit: ALU result staged through
// LATENCY-1 slots plus a write-back register, with per-stage forwarding taps.
// Stage widths come from the package struct, so DATA_W/ADDR_W must match it.
module simple_fixed2_pipe
    import spu_fx2_pkg::*;
#(
    parameter int DATA_W  = FX2_DATA_W,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = FX2_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    simple_fixed2_pipe_if.slave  bus
);

    localparam int STAGES = LATENCY - 1;

    stage_t            stage_r [STAGES];
    stage_t            wb_r;
    stage_t            issue_s;
    logic [0:DATA_W-1] alu_result_s;
    logic              alu_valid_s;

    fx2_shift_rot_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (bus.op),
        .format (bus.format),
        .ra     (bus.ra),
        .rb     (bus.rb),
        .imm    (bus.imm),
        .result (alu_result_s),
        .valid  (alu_valid_s)
    );

    // Build the slot entering stage 0; anything the ALU rejects becomes a bubble
    always_comb begin
        issue_s = '0;
        if (alu_valid_s) begin
            issue_s.data = alu_result_s;
            issue_s.addr = bus.rt_addr;
            issue_s.we   = bus.reg_write;
        end else begin
            issue_s = '0;
        end
    end

    // Advance the staging line with reset > flush > stall > advance priority
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= '0;
            end
            wb_r <= '0;
        end else if (bus.stall) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k];
            end
            wb_r <= wb_r;
        end else begin
            stage_r[0] <= issue_s;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
            wb_r <= stage_r[STAGES-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_tap
        assign bus.fwd_data[k*DATA_W +: DATA_W] = stage_r[k].data;
        assign bus.fwd_addr[k*ADDR_W +: ADDR_W] = stage_r[k].addr;
        assign bus.fwd_we[k]                    = stage_r[k].we;
    end

    // The last tap mirrors the write-back register.
    assign bus.fwd_data[STAGES*DATA_W +: DATA_W] = wb_r.data;
    assign bus.fwd_addr[STAGES*ADDR_W +: ADDR_W] = wb_r.addr;
    assign bus.fwd_we[STAGES]                    = wb_r.we;

    assign bus.rt_wb        = wb_r.data;
    assign bus.rt_addr_wb   = wb_r.addr;
    assign bus.reg_write_wb = wb_r.we;

endmodule

// File: tb/tb_simple_fixed2_pipe.sv
// Self-checking bench for simple_fixed2_pipe: directed scenarios followed by
// randomized issue/stall/flush/reset traffic against a history-queue model.
module tb_simple_fixed2_pipe;

    localparam int DW = 128;
    localparam int L  = 4;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    simple_fixed2_pipe_if #(.DATA_W(DW), .LATENCY(L), .ADDR_W(AW)) bus ();

    simple_fixed2_pipe #(.DATA_W(DW), .LATENCY(L), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [0:DW-1] data;
        logic [AW-1:0] addr;
        logic          we;
    } exp_t;

    // hist[last] is the newest slot; tap k holds hist[last-k], write-back is hist[0].
    exp_t hist[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0]   cur_op;
    logic [2:0]    cur_fmt;
    logic [AW-1:0] cur_rt;
    logic [0:DW-1] cur_ra;
    logic [0:DW-1] cur_rb;
    logic [6:0]    cur_imm7;
    logic [10:0]   cur_imm_hi;
    logic          cur_we;
    logic          cur_stall;
    logic          cur_flush;

    bit            log_en = 1'b0;
    logic [AW-1:0] obs[$];

    logic [10:0] rr_ops [4] = '{11'b00001011111, 11'b00001011011, 11'b00001011100, 11'b00001011000};
    logic [9:0]  ri_ops [4] = '{10'b0000111111, 10'b0000111101, 10'b0000111110, 10'b0000111100};

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode by opcode table, then per-element integer arithmetic.
    function automatic exp_t ref_calc(input logic [10:0] opv, input logic [2:0] fmt,
                                      input logic [AW-1:0] rt, input logic [0:DW-1] a,
                                      input logic [0:DW-1] b, input logic [6:0] i7,
                                      input logic we);
        exp_t   r;
        int     kind;
        int     w;
        int     s;
        longint x, cnt, c, y, mask, modw;
        r.data = '0;
        r.addr = '0;
        r.we   = 1'b0;
        kind   = 0;
        if (fmt == 3'd0) begin
            for (int i = 0; i < 4; i++) if (opv == rr_ops[i]) kind = i + 1;
        end else if (fmt == 3'd1) begin
            for (int i = 0; i < 4; i++) if (opv[10:1] == ri_ops[i]) kind = i + 1;
        end
        if (kind == 0) return r;
        s    = i7[6] ? int'(i7) - 128 : int'(i7);
        w    = (kind == 1 || kind == 3) ? 16 : 32;
        mask = (kind == 1) ? 31 : (kind == 2) ? 63 : (kind == 3) ? 15 : 31;
        modw = longint'(1) << w;
        for (int e = 0; e < DW / w; e++) begin
            if (w == 16) begin
                x = a[e*16 +: 16];
                if (fmt == 3'd1) cnt = s; else cnt = b[e*16 +: 16];
            end else begin
                x = a[e*32 +: 32];
                if (fmt == 3'd1) cnt = s; else cnt = b[e*32 +: 32];
            end
            c = cnt & mask;
            if (kind == 1 || kind == 2) y = (c >= w) ? 0 : ((x << c) & (modw - 1));
            else                        y = ((x << c) | (x >> (w - c))) & (modw - 1);
            if (w == 16) r.data[e*16 +: 16] = y[15:0];
            else         r.data[e*32 +: 32] = y[31:0];
        end
        r.addr = rt;
        r.we   = we;
        return r;
    endfunction

    task automatic push_bubbles();
        exp_t bub;
        bub.data = '0;
        bub.addr = '0;
        bub.we   = 1'b0;
        repeat (L) hist.push_back(bub);
    endtask

    task automatic model_update();
        if (reset || cur_flush) push_bubbles();
        else if (!cur_stall)
            hist.push_back(ref_calc(cur_op, cur_fmt, cur_rt, cur_ra, cur_rb, cur_imm7, cur_we));
        while (hist.size() > L) void'(hist.pop_front());
    endtask

    task automatic check_outputs();
        exp_t e;
        for (int k = 0; k < L; k++) begin
            e = hist[L-1-k];
            check_val($sformatf("tap%0d", k),
                      {bus.fwd_data[k*DW +: DW], bus.fwd_addr[k*AW +: AW], bus.fwd_we[k]},
                      {e.data, e.addr, e.we});
        end
        e = hist[0];
        check_val("wb", {bus.rt_wb, bus.rt_addr_wb, bus.reg_write_wb}, {e.data, e.addr, e.we});
    endtask

    task automatic drive();
        bus.op        = cur_op;
        bus.format    = cur_fmt;
        bus.rt_addr   = cur_rt;
        bus.ra        = cur_ra;
        bus.rb        = cur_rb;
        bus.imm       = {cur_imm_hi, cur_imm7};
        bus.reg_write = cur_we;
        bus.stall     = cur_stall;
        bus.flush     = cur_flush;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        if (log_en && bus.reg_write_wb) obs.push_back(bus.rt_addr_wb);
    endtask

    function automatic logic [0:DW-1] rand_vec();
        logic [0:DW-1] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic set_op(input logic [10:0] opv, input logic [2:0] fmt, input logic [AW-1:0] rt,
                          input logic [0:DW-1] a, input logic [0:DW-1] b, input logic [6:0] i7,
                          input logic we);
        cur_op     = opv;
        cur_fmt    = fmt;
        cur_rt     = rt;
        cur_ra     = a;
        cur_rb     = b;
        cur_imm7   = i7;
        cur_imm_hi = 11'($urandom());
        cur_we     = we;
        cur_stall  = 1'b0;
        cur_flush  = 1'b0;
        drive();
    endtask

    task automatic set_nop();
        set_op(11'd0, 3'd0, 7'd0, rand_vec(), rand_vec(), 7'($urandom()), 1'b0);
    endtask

    task automatic set_random_op();
        int sel;
        sel = $urandom_range(0, 10);
        if (sel < 4)
            set_op(rr_ops[sel], 3'd0, 7'($urandom()), rand_vec(), rand_vec(), 7'($urandom()), 1'($urandom()));
        else if (sel < 8)
            set_op({ri_ops[sel-4], 1'($urandom())}, 3'd1, 7'($urandom()), rand_vec(), rand_vec(),
                   7'($urandom()), 1'($urandom()));
        else if (sel == 8)
            set_op(11'd0, 3'd0, 7'($urandom()), rand_vec(), rand_vec(), 7'($urandom()), 1'b1);
        else if (sel == 9)
            set_op(11'($urandom()), 3'($urandom_range(0, 1)), 7'($urandom()), rand_vec(), rand_vec(),
                   7'($urandom()), 1'b1);
        else
            set_op(rr_ops[$urandom_range(0, 3)], 3'($urandom_range(2, 7)), 7'($urandom()), rand_vec(),
                   rand_vec(), 7'($urandom()), 1'b1);
    endtask

    initial begin
        logic [AW-1:0] exp_addrs [4];
        exp_addrs = '{7'd10, 7'd11, 7'd12, 7'd13};
        push_bubbles();

        // Reset held for two edges.
        reset = 1'b1;
        set_nop();
        step();
        step();
        check_val("rst_rt_wb", bus.rt_wb, '0);
        check_val("rst_we_wb", bus.reg_write_wb, 1'b0);
        check_val("rst_fwd_we", bus.fwd_we, '0);
        reset = 1'b0;

        // shlh: 1 << 4 in every halfword.
        set_op(rr_ops[0], 3'd0, 7'd5, {8{16'h0001}}, {8{16'h0004}}, 7'd0, 1'b1);
        step();
        set_nop();
        repeat (L - 1) step();
        check_val("shlh_data", bus.rt_wb, {8{16'h0010}});
        check_val("shlh_addr", bus.rt_addr_wb, 7'd5);
        check_val("shlh_we", bus.reg_write_wb, 1'b1);

        // shl with count 32 clears the word.
        set_op(rr_ops[1], 3'd0, 7'd6, {4{32'hFFFF_FFFF}}, {4{32'h0000_0020}}, 7'd0, 1'b1);
        step();
        set_nop();
        repeat (L - 1) step();
        check_val("shl32_data", bus.rt_wb, '0);
        check_val("shl32_we", bus.reg_write_wb, 1'b1);

        // roti with immediate -1 rotates by 31.
        set_op({ri_ops[3], 1'b0}, 3'd1, 7'd7, {4{32'h8000_0001}}, rand_vec(), 7'h7F, 1'b1);
        step();
        set_nop();
        repeat (L - 1) step();
        check_val("roti_data", bus.rt_wb, {4{32'hC000_0000}});
        check_val("roti_addr", bus.rt_addr_wb, 7'd7);

        // Three back-to-back ops, flush with the third.
        for (int i = 0; i < 3; i++) begin
            set_op(rr_ops[i], 3'd0, 7'(i + 1), rand_vec(), rand_vec(), 7'd0, 1'b1);
            cur_flush = (i == 2);
            drive();
            step();
        end
        set_nop();
        for (int i = 0; i < L + 1; i++) begin
            step();
            check_val("flush_we_wb", bus.reg_write_wb, 1'b0);
        end
        set_op(rr_ops[3], 3'd0, 7'd9, rand_vec(), rand_vec(), 7'd0, 1'b1);
        step();
        set_nop();
        repeat (L - 1) step();
        check_val("post_flush_we", bus.reg_write_wb, 1'b1);
        check_val("post_flush_addr", bus.rt_addr_wb, 7'd9);

        // Stall for three cycles mid-stream; inputs during the stall are dropped.
        obs.delete();
        log_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_op(rr_ops[i], 3'd0, 7'(10 + i), rand_vec(), rand_vec(), 7'd0, 1'b1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            set_op(rr_ops[2], 3'd0, 7'(20 + i), rand_vec(), rand_vec(), 7'd0, 1'b1);
            cur_stall = 1'b1;
            drive();
            step();
        end
        for (int i = 0; i < 2; i++) begin
            set_op({ri_ops[i], 1'b1}, 3'd1, 7'(12 + i), rand_vec(), rand_vec(), 7'($urandom()), 1'b1);
            step();
        end
        set_nop();
        repeat (L) step();
        log_en = 1'b0;
        check_val("stall_wb_count", 256'(obs.size()), 256'(4));
        for (int i = 0; i < 4 && i < obs.size(); i++)
            check_val($sformatf("stall_order%0d", i), obs[i], exp_addrs[i]);

        // Undefined opcode, unsupported format and RR nop with reg_write set.
        set_op(11'h7FF, 3'd0, 7'd15, rand_vec(), rand_vec(), 7'd0, 1'b1);
        step();
        set_op(rr_ops[1], 3'd5, 7'd16, rand_vec(), rand_vec(), 7'd0, 1'b1);
        step();
        set_op(11'd0, 3'd0, 7'd17, rand_vec(), rand_vec(), 7'd0, 1'b1);
        step();
        set_nop();
        for (int i = 0; i < L; i++) begin
            step();
            check_val("bubble_we_wb", bus.reg_write_wb, 1'b0);
        end

        // Randomized traffic with stalls, flushes and occasional reset.
        for (int n = 0; n < 400; n++) begin
            set_random_op();
            cur_stall = ($urandom_range(0, 7) == 0);
            cur_flush = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            drive();
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
